// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each bit is held for CLK_FREQ/BAUD_RATE clocks and tx is driven straight from a flop.
module uart_tx #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  // Mode 3 is not a legal parity setting and falls back to no parity.
  localparam int          PAR_MODE  = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
  localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic        stop_cnt;
  logic        bit_end;

  assign bit_end  = (clk_cnt == DIV_LAST);
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);

  // Each branch loads the tx flop with the level of the bit that starts on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      clk_cnt  <= 16'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift   <= tx_data;
            par_bit <= (PAR_MODE == 2) ? ~(^tx_data) : (^tx_data);
            clk_cnt <= 16'd0;
            tx      <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt <= 16'd0;
            bit_cnt <= 3'd0;
            tx      <= shift[0];
            state   <= ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= 16'd0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (PAR_MODE != 0) begin
                tx    <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              tx <= shift[bit_cnt + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            clk_cnt  <= 16'd0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            clk_cnt <= 16'd0;
            if (stop_cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations, a line-sampling receiver per instance feeding a scoreboard,
// plus directed timing checks on frame length, latency, stop-bit gap and reset.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DIV = 104;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_v  [4];
  logic       valid_v [4];
  logic       tx_v    [4];
  logic       ready_v [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic       hist    [2500];

  int checks = 0;
  int errors = 0;
  int frames_seen [4] = '{0, 0, 0, 0};
  frame_t exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(0), .STOP_BITS(2)) dut_d (
    .clk(clk), .rst(rst), .tx_data(data_v[3]), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic pushExp(input int k, input logic [7:0] d, input logic p);
    frame_t f;
    f.data = d;
    f.par  = p;
    case (k)
      0: exp_q0.push_back(f);
      1: exp_q1.push_back(f);
      2: exp_q2.push_back(f);
      default: exp_q3.push_back(f);
    endcase
  endtask

  task automatic popExp(input int k, output frame_t f, output bit have);
    have = 1'b0;
    f    = '0;
    case (k)
      0: if (exp_q0.size() > 0) begin f = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin f = exp_q1.pop_front(); have = 1'b1; end
      2: if (exp_q2.size() > 0) begin f = exp_q2.pop_front(); have = 1'b1; end
      default: if (exp_q3.size() > 0) begin f = exp_q3.pop_front(); have = 1'b1; end
    endcase
  endtask

  task automatic waitCycles(input int n, inout bit aborted);
    if (aborted) return;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Receiver model: finds the start edge, then samples every bit at its centre.
  task automatic monitorLine(input int k, input bit has_par, input int stops);
    logic [7:0] got;
    logic       gpar;
    logic       stop_ok;
    bit         aborted;
    bit         have;
    frame_t     f;
    forever begin
      @(negedge clk);
      if (!rst && tx_v[k] === 1'b0) begin
        aborted = 1'b0;
        got     = 8'd0;
        gpar    = 1'b0;
        stop_ok = 1'b1;
        waitCycles(DIV / 2, aborted);
        if (!aborted) checkOutput($sformatf("dut%0d start centre", k), tx_v[k], 1'b0);
        for (int i = 0; i < 8; i++) begin
          waitCycles(DIV, aborted);
          got[i] = tx_v[k];
        end
        if (has_par) begin
          waitCycles(DIV, aborted);
          gpar = tx_v[k];
        end
        for (int s = 0; s < stops; s++) begin
          waitCycles(DIV, aborted);
          if (tx_v[k] !== 1'b1) stop_ok = 1'b0;
        end
        if (!aborted) begin
          frames_seen[k]++;
          popExp(k, f, have);
          checkOutput($sformatf("dut%0d frame expected", k), {31'd0, have}, 32'd1);
          if (have) begin
            checkOutput($sformatf("dut%0d data", k), {24'd0, got}, {24'd0, f.data});
            if (has_par) checkOutput($sformatf("dut%0d parity", k), {31'd0, gpar}, {31'd0, f.par});
          end
          checkOutput($sformatf("dut%0d stop bits", k), {31'd0, stop_ok}, 32'd1);
        end
      end
    end
  endtask

  initial monitorLine(0, 1'b0, 1);
  initial monitorLine(1, 1'b1, 1);
  initial monitorLine(2, 1'b1, 1);
  initial monitorLine(3, 1'b0, 2);

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic applyStimulus(input int k, input logic [7:0] d, input logic exp_par,
                               input bit expect_frame, input bit hold);
    int n = 0;
    while (ready_v[k] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) reportTimeout($sformatf("dut%0d ready", k));
    if (expect_frame) pushExp(k, d, exp_par);
    data_v[k]  = d;
    valid_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid_v[k] = 1'b0;
  endtask

  // hist[c] holds tx in cycle N+c, where N is the handshake edge.
  task automatic timeFrame(input int k, output int cnt, output int ready_bad);
    cnt       = 1;
    ready_bad = 0;
    hist[1]   = tx_v[k];
    while (done_v[k] !== 1'b1 && cnt < 2400) begin
      if (ready_v[k] !== 1'b0) ready_bad++;
      @(negedge clk);
      cnt++;
      hist[cnt] = tx_v[k];
    end
    if (cnt >= 2400) reportTimeout($sformatf("dut%0d tx_done", k));
  endtask

  task automatic waitDone(input int k);
    int n = 0;
    while (done_v[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) reportTimeout($sformatf("dut%0d wait done", k));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int ready_bad;
    int n;
    int lows;
    int dones;
    logic [7:0] loop_bytes [4];
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h5A;
    loop_bytes[3] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      valid_v[k] = 1'b0;
      data_v[k]  = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    valid_v[0] = 1'b1;
    @(negedge clk);
    checkOutput("reset tx", tx_v[0], 1'b1);
    checkOutput("reset ready", ready_v[0], 1'b1);
    checkOutput("reset busy", busy_v[0], 1'b0);
    checkOutput("reset done", done_v[0], 1'b0);
    valid_v[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single byte 0x55");
    applyStimulus(0, 8'h55, 1'b0, 1'b1, 1'b0);
    timeFrame(0, cnt, ready_bad);
    // tx_done set on edge N+1040, so first visible in cycle N+1041.
    checkOutput("0x55 done cycle", cnt, 1041);
    checkOutput("0x55 ready low in frame", ready_bad, 0);
    checkOutput("0x55 ready with done", ready_v[0], 1'b1);
    checkOutput("0x55 start first cycle", hist[1], 1'b0);
    checkOutput("0x55 start last cycle", hist[104], 1'b0);
    checkOutput("0x55 bit0 first cycle", hist[105], 1'b1);
    checkOutput("0x55 bit1 first cycle", hist[209], 1'b0);
    checkOutput("0x55 bit7 last cycle", hist[936], 1'b0);
    checkOutput("0x55 stop first cycle", hist[937], 1'b1);
    checkOutput("0x55 stop last cycle", hist[1040], 1'b1);
    @(negedge clk);
    checkOutput("0x55 done one cycle", done_v[0], 1'b0);

    $display("[TB] reset mid start bit");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset tx", tx_v[0], 1'b1);
    checkOutput("midreset ready", ready_v[0], 1'b1);
    checkOutput("midreset busy", busy_v[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) lows++;
      if (done_v[0] !== 1'b0) dones++;
    end
    checkOutput("after reset tx low cycles", lows, 0);
    checkOutput("after reset done pulses", dones, 0);

    $display("[TB] input stability 0x3C");
    applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    cnt = 1;
    while (done_v[0] !== 1'b1 && cnt < 2400) begin
      valid_v[0] = busy_v[0] ? ~valid_v[0] : 1'b0;
      data_v[0]  = 8'($urandom);
      @(negedge clk);
      cnt++;
    end
    valid_v[0] = 1'b0;
    if (cnt >= 2400) reportTimeout("0x3C done");
    checkOutput("0x3C done cycle", cnt, 1041);
    @(negedge clk);
    checkOutput("0x3C no extra handshake", busy_v[0], 1'b0);

    $display("[TB] parity 0xA5");
    applyStimulus(1, 8'hA5, 1'b0, 1'b1, 1'b0);
    timeFrame(1, cnt, ready_bad);
    checkOutput("even parity done cycle", cnt, 1145);
    checkOutput("even parity bit centre", hist[988], 1'b0);
    checkOutput("even parity stop last", hist[1144], 1'b1);
    applyStimulus(2, 8'hA5, 1'b1, 1'b1, 1'b0);
    timeFrame(2, cnt, ready_bad);
    checkOutput("odd parity done cycle", cnt, 1145);
    checkOutput("odd parity bit centre", hist[988], 1'b1);
    checkOutput("odd ready low in frame", ready_bad, 0);

    $display("[TB] two stop bits back to back");
    applyStimulus(3, 8'h00, 1'b0, 1'b1, 1'b1);
    data_v[3] = 8'hFF;
    pushExp(3, 8'hFF, 1'b0);
    cnt = 1;
    while (tx_v[3] !== 1'b1 && cnt < 2400) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("stop2 first mark cycle", cnt, 937);
    n = 0;
    while (tx_v[3] === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    valid_v[3] = 1'b0;
    checkOutput("stop2 idle gap", n, 209);
    waitDone(3);

    $display("[TB] loopback stream");
    for (int i = 0; i < 4; i++) applyStimulus(0, loop_bytes[i], 1'b0, 1'b1, (i < 3));
    waitDone(0);
    repeat (20) @(negedge clk);

    checkOutput("dut0 leftover", exp_q0.size(), 0);
    checkOutput("dut1 leftover", exp_q1.size(), 0);
    checkOutput("dut2 leftover", exp_q2.size(), 0);
    checkOutput("dut3 leftover", exp_q3.size(), 0);
    checkOutput("dut0 frame count", frames_seen[0], 6);
    checkOutput("dut1 frame count", frames_seen[1], 1);
    checkOutput("dut2 frame count", frames_seen[2], 1);
    checkOutput("dut3 frame count", frames_seen[3], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Asynchronous serial transmitter: accepts one byte per valid/ready handshake and shifts it out on a single line as a UART frame. The frame is 1 start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. It is the transmit half of the UART and pairs with the existing UART receiver on the same clock/baud parameters. Bit timing is derived from a free-running-per-bit clock divider; no oversampling is needed on this side.

## Interface
- CLK_FREQ, 1000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate in baud
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd; 3 is illegal and is treated as 0
- STOP_BITS, 1, number of stop bits; legal values 1 or 2
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- tx_data  input  8  byte to send, sampled only on handshake
- tx_valid  input  1  producer has a byte on tx_data
- tx_ready  output  1  transmitter can accept a byte this cycle
- tx  output  1  serial line, idle/mark = 1
- tx_busy  output  1  frame in progress (state not IDLE)
- tx_done  output  1  one-cycle pulse when a frame's last stop bit completes

## Operation
- BAUD_DIV = CLK_FREQ / BAUD_RATE, integer division, truncated.
- BAUD_DIV must satisfy 2 ≤ BAUD_DIV ≤ 65535. The divider clk_cnt is 16 bits.
- Every bit, including start, parity and each stop bit, is held on tx for exactly BAUD_DIV clocks.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, tx_ready = 1.
  - On a rising edge with tx_valid && tx_ready: latch tx_data into the shift register, compute the parity bit from the latched byte, clear clk_cnt, go to START.
- START:
  - tx = 0.
  - When clk_cnt == BAUD_DIV-1: clear clk_cnt and bit_cnt, go to DATA. Otherwise increment clk_cnt.
- DATA:
  - tx = shift[bit_cnt], so bit 0 goes first.
  - At end of each bit period, increment bit_cnt.
  - After bit 7, go to PARITY if PARITY ≠ 0, else go to STOP with the stop counter cleared.
- PARITY:
  - Even mode: tx = XOR of the 8 data bits.
  - Odd mode: tx = inverse of that XOR.
  - After one bit period, go to STOP.
- STOP:
  - tx = 1 for STOP_BITS bit periods.
  - At the end of the last one: go to IDLE, pulse tx_done for 1 cycle, and raise tx_ready.
- tx_data changes while not in IDLE are ignored. The latched byte is used for the whole frame.
- tx_valid deasserting mid-frame has no effect. There is no abort.
- tx_busy = (state ≠ IDLE). tx_ready = (state == IDLE). Both are registered-state decodes and glitch-free.
- tx must be driven from a flop, not from combinational decode.

## Timing
- Reset values while rst is high, and immediately on assertion:
  - state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0
  - clk_cnt, bit_cnt and the shift register = 0
- Handshakes are ignored while rst is high.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is truncated. The next frame starts only after a new handshake.
- Latency: the handshake is at edge N. tx falls in the cycle after edge N, and the start bit spans cycles N+1 .. N+BAUD_DIV.
- Frame length on tx: (1 + 8 + P + STOP_BITS) × BAUD_DIV cycles, where P = 1 if parity is enabled, else 0.
- tx_done is high in the cycle immediately after the last stop-bit cycle, which is the same cycle tx_ready returns to 1.
- Back-to-back frames: if tx_valid is held high, the next byte is accepted on the edge ending that first IDLE cycle. Minimum line idle between frames is therefore STOP_BITS × BAUD_DIV + 1 cycles of mark.
- Wrap-around: clk_cnt resets to 0 at the end of every bit and never wraps past BAUD_DIV-1. bit_cnt never exceeds 7 in DATA.

## Test plan
- Reset: assert rst mid-start-bit with the default config (BAUD_DIV = 104) -> tx = 1, tx_ready = 1, tx_busy = 0 within the same cycle. No tx_done pulse, and tx stays 1 until the next handshake.
- Single byte 0x55, default config -> tx = 0 for 104 cycles, then the data bits 1,0,1,0,1,0,1,0 at 104 cycles each, then stop = 1 for 104 cycles.
  - tx_done pulses exactly 1040 cycles after the handshake edge.
  - tx_ready is low throughout the frame.
- Parity with byte 0xA5 (four ones), sampled at each bit centre:
  - PARITY = 1 -> parity bit 0.
  - PARITY = 2 -> parity bit 1.
  - The frame is 11 bit periods (1144 cycles).
- STOP_BITS = 2 with tx_valid held high and bytes 0x00 then 0xFF -> the second start bit begins exactly 208 + 1 cycles after the first frame's last data bit ends. The second frame's data is all ones.
- Input stability: change tx_data and toggle tx_valid every cycle during a 0x3C frame -> the transmitted bits match 0x3C and no extra handshake is accepted while busy.
- Loopback into the UART receiver at default parameters, sending 0x00, 0xFF, 0x5A and 0xC3 back-to-back -> the receiver reports each byte once and in order.
